apb_master_fsm: RTL and testbench
=================================

APB_MASTER_FSM -- requirements
Module: apb_master_fsm

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the APB data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, the APB address width.
REQ-003 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8, the byte strobes.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16, the maximum wait-state ACCESS cycles.
REQ-005 SHALL use one clock and an asynchronous active-low reset: PCLK  in  1  clock; PRESETn  in  1  reset.
REQ-006 SHALL have cmd_valid  in  1  command offered; cmd_ready  out  1  command accepted.
REQ-007 SHALL have cmd_addr  in  ADDR_WIDTH; cmd_write  in  1; cmd_wdata  in  DATA_WIDTH; cmd_strb  in  STRB_WIDTH; cmd_prot  in  3.
REQ-008 SHALL have rsp_valid  out  1; rsp_ready  in  1; rsp_rdata  out  DATA_WIDTH; rsp_err  out  1; rsp_timeout  out  1.
REQ-009 SHALL have the APB outputs PADDR  ADDR_WIDTH, PPROT  3, PSELx  1, PENABLE  1, PWRITE  1, PWDATA  DATA_WIDTH, PSTRB  STRB_WIDTH.
REQ-010 SHALL have the APB inputs PREADY  1, PRDATA  DATA_WIDTH, PSLVERR  1.

Function
REQ-011 SHALL implement the states IDLE, SETUP, ACCESS and RESP with one-hot encoding.
REQ-012 SHALL drive every output from a register, with no combinational path from an input to an output.
REQ-013 SHALL drive cmd_ready=1 only in IDLE; cmd_valid&cmd_ready SHALL capture addr/write/wdata/strb/prot and move to SETUP.
REQ-014 SHALL drive SETUP as one cycle: PSELx=1, PENABLE=0, with PADDR/PWRITE/PWDATA/PSTRB/PPROT from the captured command; next state ACCESS unconditionally.
REQ-015 SHALL drive ACCESS as PSELx=1, PENABLE=1, with all APB address/control/data outputs held stable.
REQ-016 SHALL drive PSTRB to all-zero for reads (cmd_write=0), regardless of cmd_strb.
REQ-017 In ACCESS with PREADY=1: SHALL register rsp_rdata=PRDATA on a read or 0 on a write, register rsp_err=PSLVERR, set rsp_timeout=0, and go to RESP.
REQ-018 In ACCESS with PREADY=0: SHALL increment the wait counter; the counter SHALL clear on entering SETUP.
REQ-019 SHALL take the timeout branch when PREADY=0 on the TIMEOUT_CYCLES-th ACCESS cycle: rsp_err=1, rsp_timeout=1, rsp_rdata=0, go to RESP.
REQ-020 SHALL give PREADY=1 priority over timeout on the same cycle.
REQ-021 SHALL size the wait counter to $clog2(TIMEOUT_CYCLES+1) bits so that it never wraps.
REQ-022 SHALL drive RESP as PSELx=0, PENABLE=0, rsp_valid=1, with rsp_* held stable until rsp_ready=1, then go to IDLE.
REQ-023 SHALL hold cmd_ready=0 for the whole of SETUP, ACCESS and RESP; a command offered meanwhile SHALL wait.
REQ-024 SHALL drive PSELx=0 and PENABLE=0 in IDLE; PADDR/PWDATA SHALL hold their last values.
REQ-025 SHALL keep the zero-wait-state latency fixed: accept in cycle N, SETUP N+1, ACCESS N+2, rsp_valid N+3; if rsp_ready=1, the next cmd_ready is N+4.
REQ-026 SHALL never assert PENABLE without PSELx.

Reset
REQ-027 SHALL, on asserting PRESETn=0, immediately force IDLE, PSELx=0, PENABLE=0, cmd_ready=0 and rsp_valid=0, with all data/address/strobe/prot/error outputs at 0.
REQ-028 SHALL abandon any in-flight transfer or pending response on reset, with no response issued.
REQ-029 SHALL raise cmd_ready=1 on the first PCLK edge after PRESETn deasserts.

Structure
REQ-030 SHALL place the state localparams and the DATA_WIDTH/ADDR_WIDTH defaults in shared package apb_pkg, also used by the APB slave.
REQ-031 SHALL implement the wait counter plus timeout compare as sub-module apb_wait_timer (ports: PCLK, PRESETn, clr, en, expired).
REQ-032 SHALL keep the RTL within 120-400 lines, with no memories.

Verification
REQ-033 Write with addr 0x10, wdata 0xA5, strb 1, PREADY=1 -> SETUP then ACCESS one cycle each; rsp_valid at N+3 with rsp_err=0.
REQ-034 Read with addr 0x20, PREADY high after 3 waits, PRDATA 0x3C -> PENABLE high 4 cycles; rsp_rdata=0x3C; PSTRB=0 throughout.
REQ-035 PREADY held 0 -> exactly 16 ACCESS cycles, then rsp_err=1, rsp_timeout=1, PSELx=0.
REQ-036 PREADY=1 with PSLVERR=1 on a write -> rsp_err=1, rsp_timeout=0.
REQ-037 rsp_ready held 0 for 5 cycles while cmd_valid=1 -> rsp_* stable; cmd_ready=0; the next transfer starts only after the handshake.
REQ-038 PRESETn pulsed low mid-ACCESS -> PSELx/PENABLE=0 within the same cycle; no rsp_valid; a clean transfer follows.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: default bus widths and one-hot state encoding,
// used by both the APB master FSM and the APB slave.
package apb_pkg;

    // Default bus widths
    localparam int APB_DATA_WIDTH = 8;
    localparam int APB_ADDR_WIDTH = 8;

    // One-hot state bit positions
    localparam int ST_NUM        = 4;
    localparam int ST_IDLE_BIT   = 0;
    localparam int ST_SETUP_BIT  = 1;
    localparam int ST_ACCESS_BIT = 2;
    localparam int ST_RESP_BIT   = 3;

    // One-hot state vectors
    localparam logic [ST_NUM-1:0] ST_IDLE   = ST_NUM'(1) << ST_IDLE_BIT;
    localparam logic [ST_NUM-1:0] ST_SETUP  = ST_NUM'(1) << ST_SETUP_BIT;
    localparam logic [ST_NUM-1:0] ST_ACCESS = ST_NUM'(1) << ST_ACCESS_BIT;
    localparam logic [ST_NUM-1:0] ST_RESP   = ST_NUM'(1) << ST_RESP_BIT;

endpackage : apb_pkg

// File: rtl/apb_master_fsm_if.sv
// Command/response channel plus APB bus, bundled for the master FSM.
// The master modport is the FSM's view; the slave modport is the view of
// whatever sits on the other side (command source, APB completer, bench).
interface apb_master_fsm_if
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH = APB_DATA_WIDTH,
    parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);

    // Command channel
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic                  cmd_write;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic [STRB_WIDTH-1:0] cmd_strb;
    logic [2:0]            cmd_prot;

    // Response channel
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    // APB requester outputs
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [2:0]            PPROT;
    logic                  PSELx;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [STRB_WIDTH-1:0] PSTRB;

    // APB completer outputs
    logic                  PREADY;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_strb, cmd_prot,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output PADDR, PPROT, PSELx, PENABLE, PWRITE, PWDATA, PSTRB,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_strb, cmd_prot,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  PADDR, PPROT, PSELx, PENABLE, PWRITE, PWDATA, PSTRB,
        output PREADY, PRDATA, PSLVERR
    );

endinterface : apb_master_fsm_if

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait states and flags the cycle on which the transfer
// must be abandoned. The counter saturates one above the last legal
// value, so it can never wrap back into range.
module apb_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic clr,      // new transfer entering SETUP
    input  logic en,       // ACCESS cycle with PREADY low
    output logic expired   // this wait is the last one allowed
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear on a new transfer, otherwise count waits up to saturation
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The count holds the number of waits already seen; when it equals
    // TIMEOUT_CYCLES-1 the current ACCESS cycle is the TIMEOUT_CYCLES-th.
    assign expired = en && (cnt_q == CNT_LAST);

endmodule : apb_wait_timer

// File: rtl/apb_master_fsm.sv
// APB requester: accepts one command at a time, runs the SETUP/ACCESS
// phases with a bounded number of wait states, and returns the result on
// a valid/ready response channel. Every output comes straight from a flop.
module apb_master_fsm
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    apb_master_fsm_if.master bus
);

    // State
    logic [ST_NUM-1:0]     state_q;
    logic [ST_NUM-1:0]     state_d;

    // Registered outputs
    logic                  cmd_ready_q,   cmd_ready_d;
    logic                  rsp_valid_q,   rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q,   rsp_rdata_d;
    logic                  rsp_err_q,     rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic [ADDR_WIDTH-1:0] paddr_q,       paddr_d;
    logic [2:0]            pprot_q,       pprot_d;
    logic                  psel_q,        psel_d;
    logic                  penable_q,     penable_d;
    logic                  pwrite_q,      pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q,      pwdata_d;
    logic [STRB_WIDTH-1:0] pstrb_q,       pstrb_d;

    // Decoded events
    logic                  accept;
    logic                  in_access;
    logic                  wait_en;
    logic                  timer_expired;
    logic                  done_ok;
    logic                  done_timeout;
    logic [STRB_WIDTH-1:0] strb_masked;

    // cmd_ready_q is only ever high in IDLE, so it doubles as the IDLE
    // qualifier for the handshake and keeps the first post-reset cycle closed.
    assign accept       = cmd_ready_q & bus.cmd_valid;
    assign in_access    = state_q[ST_ACCESS_BIT];
    assign wait_en      = in_access & ~bus.PREADY;
    assign done_ok      = in_access & bus.PREADY;
    assign done_timeout = wait_en & timer_expired;

    // Reads never carry byte strobes
    genvar gi;
    generate
        for (gi = 0; gi < STRB_WIDTH; gi++) begin : g_strb
            assign strb_masked[gi] = bus.cmd_write & bus.cmd_strb[gi];
        end
    endgenerate

    apb_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .clr     (accept),
        .en      (wait_en),
        .expired (timer_expired)
    );

    // State register and all output registers
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= ST_IDLE;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            paddr_q       <= '0;
            pprot_q       <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            paddr_q       <= paddr_d;
            pprot_q       <= pprot_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
        end
    end

    // Next-state logic over the one-hot state vector
    always_comb begin
        state_d = state_q;
        case (1'b1)
            state_q[ST_IDLE_BIT]: begin
                if (accept) begin
                    state_d = ST_SETUP;
                end
            end
            state_q[ST_SETUP_BIT]: begin
                state_d = ST_ACCESS;
            end
            state_q[ST_ACCESS_BIT]: begin
                // PREADY wins over timeout on the same cycle
                if (bus.PREADY || timer_expired) begin
                    state_d = ST_RESP;
                end
            end
            state_q[ST_RESP_BIT]: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: bus phase flags follow the next state so they line up
    // with it; data registers load on capture and on transfer completion.
    always_comb begin
        cmd_ready_d   = state_d[ST_IDLE_BIT];
        rsp_valid_d   = state_d[ST_RESP_BIT];
        psel_d        = state_d[ST_SETUP_BIT] | state_d[ST_ACCESS_BIT];
        penable_d     = state_d[ST_ACCESS_BIT];

        paddr_d       = paddr_q;
        pprot_d       = pprot_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        if (accept) begin
            paddr_d  = bus.cmd_addr;
            pprot_d  = bus.cmd_prot;
            pwrite_d = bus.cmd_write;
            pwdata_d = bus.cmd_wdata;
            pstrb_d  = strb_masked;
        end

        if (done_ok) begin
            rsp_rdata_d   = pwrite_q ? '0 : bus.PRDATA;
            rsp_err_d     = bus.PSLVERR;
            rsp_timeout_d = 1'b0;
        end else if (done_timeout) begin
            rsp_rdata_d   = '0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.PADDR       = paddr_q;
    assign bus.PPROT       = pprot_q;
    assign bus.PSELx       = psel_q;
    assign bus.PENABLE     = penable_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PWDATA      = pwdata_q;
    assign bus.PSTRB       = pstrb_q;

endmodule : apb_master_fsm

// File: tb/tb_apb_master_fsm.sv
// Directed bench for apb_master_fsm: a table of single transfers with
// hand-computed results, plus sequences for reset, response back-pressure
// and reset in the middle of ACCESS.
module tb_apb_master_fsm;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_fail   = 0;

    apb_master_fsm_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .STRB_WIDTH(1)) bus ();

    apb_master_fsm #(
        .DATA_WIDTH     (8),
        .ADDR_WIDTH     (8),
        .STRB_WIDTH     (1),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .PCLK    (clk),
        .PRESETn (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       write;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       strb;
        logic [2:0] prot;
        int         waits;      // PREADY rises on ACCESS cycle waits+1
        logic [7:0] prdata;
        logic       slverr;
        logic [7:0] exp_rdata;
        logic       exp_err;
        logic       exp_to;
        int         exp_pen;    // cycles with PENABLE high
        logic       exp_pstrb;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Offer a command and wait (bounded) until it is accepted; returns on
    // the negedge of the acceptance cycle.
    task automatic offer_cmd(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                             input logic strb, input logic [2:0] prot, input string tag);
        int guard;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.cmd_strb  = strb;
        bus.cmd_prot  = prot;
        guard = 0;
        while (bus.cmd_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int acc;
        int guard;
        string t;
        t = $sformatf("v%0d", id);
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        offer_cmd(v.write, v.addr, v.wdata, v.strb, v.prot, t);
        // SETUP
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check({t, "_setup_psel"},    bus.PSELx,    1);
        check({t, "_setup_penable"}, bus.PENABLE,  0);
        check({t, "_setup_paddr"},   bus.PADDR,    v.addr);
        check({t, "_setup_pwrite"},  bus.PWRITE,   v.write);
        check({t, "_setup_pwdata"},  bus.PWDATA,   v.wdata);
        check({t, "_setup_pprot"},   bus.PPROT,    v.prot);
        check({t, "_setup_pstrb"},   bus.PSTRB,    v.exp_pstrb);
        check({t, "_setup_cmd_rdy"}, bus.cmd_ready, 0);
        // ACCESS, with the completer answering on cycle waits+1
        acc = 0;
        guard = 0;
        @(negedge clk);
        while (bus.PENABLE === 1'b1 && guard < 40) begin
            acc++;
            check({t, "_acc_psel"},  bus.PSELx, 1);
            check({t, "_acc_pstrb"}, bus.PSTRB, v.exp_pstrb);
            check({t, "_acc_paddr"}, bus.PADDR, v.addr);
            bus.PREADY  = (acc == v.waits + 1);
            bus.PRDATA  = bus.PREADY ? v.prdata : 8'hEE;
            bus.PSLVERR = bus.PREADY ? v.slverr : 1'b0;
            @(negedge clk);
            guard++;
        end
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        // RESP
        check({t, "_penable_cycles"}, acc, v.exp_pen);
        check({t, "_rsp_valid"},   bus.rsp_valid,   1);
        check({t, "_rsp_psel"},    bus.PSELx,       0);
        check({t, "_rsp_penable"}, bus.PENABLE,     0);
        check({t, "_rsp_rdata"},   bus.rsp_rdata,   v.exp_rdata);
        check({t, "_rsp_err"},     bus.rsp_err,     v.exp_err);
        check({t, "_rsp_timeout"}, bus.rsp_timeout, v.exp_to);
        check({t, "_rsp_cmd_rdy"}, bus.cmd_ready,   0);
        // Back in IDLE one cycle after the handshake
        @(negedge clk);
        check({t, "_idle_rsp_valid"}, bus.rsp_valid, 0);
        check({t, "_idle_cmd_ready"}, bus.cmd_ready, 1);
        $display("txn %0d: %s addr=0x%02h waits=%0d rdata=0x%02h err=%0d timeout=%0d penable_cycles=%0d",
                 id, v.write ? "WR" : "RD", v.addr, v.waits, bus.rsp_rdata, bus.rsp_err,
                 bus.rsp_timeout, acc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //                write  addr   wdata  strb prot  waits prdata slverr rdata  err   to    pen pstrb
        vecs[0] = '{1'b1, 8'h10, 8'hA5, 1'b1, 3'd0, 0,  8'h77, 1'b0, 8'h00, 1'b0, 1'b0, 1,  1'b1};
        vecs[1] = '{1'b0, 8'h20, 8'h00, 1'b1, 3'd1, 3,  8'h3C, 1'b0, 8'h3C, 1'b0, 1'b0, 4,  1'b0};
        vecs[2] = '{1'b1, 8'h30, 8'h5A, 1'b1, 3'd2, 99, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 16, 1'b1};
        vecs[3] = '{1'b1, 8'h40, 8'h11, 1'b0, 3'd0, 0,  8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1,  1'b0};
        vecs[4] = '{1'b0, 8'h55, 8'h00, 1'b1, 3'd4, 15, 8'hC3, 1'b0, 8'hC3, 1'b0, 1'b0, 16, 1'b0};
        vecs[5] = '{1'b0, 8'h66, 8'h00, 1'b0, 3'd7, 1,  8'h99, 1'b1, 8'h99, 1'b1, 1'b0, 2,  1'b0};
        vecs[6] = '{1'b0, 8'h70, 8'h00, 1'b1, 3'd3, 14, 8'h12, 1'b0, 8'h12, 1'b0, 1'b0, 15, 1'b0};

        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_write = 1'b0;
        bus.cmd_wdata = '0;
        bus.cmd_strb  = '0;
        bus.cmd_prot  = '0;
        bus.rsp_ready = 1'b0;
        bus.PREADY    = 1'b0;
        bus.PRDATA    = '0;
        bus.PSLVERR   = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_psel",      bus.PSELx,     0);
        check("rst_penable",   bus.PENABLE,   0);
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_paddr",     bus.PADDR,     0);
        check("rst_pwdata",    bus.PWDATA,    0);
        check("rst_pstrb",     bus.PSTRB,     0);
        check("rst_rsp_err",   bus.rsp_err,   0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", bus.cmd_ready, 1);

        // Table of single transfers
        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], i);
        end

        // Response back-pressure with a second command already waiting
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        offer_cmd(1'b1, 8'h81, 8'h42, 1'b1, 3'd0, "bp");
        @(negedge clk);                           // SETUP; next command now offered
        bus.cmd_addr  = 8'h82;
        bus.cmd_wdata = 8'h24;
        @(negedge clk);                           // ACCESS
        check("bp_penable", bus.PENABLE, 1);
        bus.PREADY = 1'b1;
        @(negedge clk);                           // RESP
        bus.PREADY = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_hold%0d_rsp_valid", k), bus.rsp_valid, 1);
            check($sformatf("bp_hold%0d_rsp_err", k),   bus.rsp_err,   0);
            check($sformatf("bp_hold%0d_cmd_ready", k), bus.cmd_ready, 0);
            check($sformatf("bp_hold%0d_psel", k),      bus.PSELx,     0);
            check($sformatf("bp_hold%0d_paddr", k),     bus.PADDR,     8'h81);
            @(negedge clk);
        end
        check("bp_last_rsp_valid", bus.rsp_valid, 1);
        bus.rsp_ready = 1'b1;
        @(negedge clk);                           // IDLE, second command accepted here
        check("bp_after_cmd_ready", bus.cmd_ready, 1);
        check("bp_after_rsp_valid", bus.rsp_valid, 0);
        @(negedge clk);                           // SETUP of second command
        bus.cmd_valid = 1'b0;
        check("bp_next_psel",   bus.PSELx,  1);
        check("bp_next_paddr",  bus.PADDR,  8'h82);
        check("bp_next_pwdata", bus.PWDATA, 8'h24);
        @(negedge clk);                           // ACCESS
        bus.PREADY = 1'b1;
        @(negedge clk);                           // RESP
        bus.PREADY = 1'b0;
        check("bp_next_rsp_valid", bus.rsp_valid, 1);
        @(negedge clk);
        check("bp_next_idle", bus.cmd_ready, 1);
        $display("txn bp: back-pressured write then queued write to 0x82");

        // Reset in the middle of ACCESS
        @(negedge clk);
        offer_cmd(1'b0, 8'h90, 8'h00, 1'b0, 3'd0, "mr");
        @(negedge clk);                           // SETUP
        bus.cmd_valid = 1'b0;
        @(negedge clk);                           // ACCESS 1
        @(negedge clk);                           // ACCESS 2
        check("mr_penable_before", bus.PENABLE, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mr_psel",      bus.PSELx,     0);
        check("mr_penable",   bus.PENABLE,   0);
        check("mr_cmd_ready", bus.cmd_ready, 0);
        check("mr_rsp_valid", bus.rsp_valid, 0);
        check("mr_paddr",     bus.PADDR,     0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("mr_post%0d_rsp_valid", k), bus.rsp_valid, 0);
            check($sformatf("mr_post%0d_cmd_ready", k), bus.cmd_ready, 1);
        end
        $display("txn mr: read to 0x90 abandoned by reset");
        run_vec(vecs[0], 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_apb_master_fsm
